gshare_btb_predictor: RTL

GSHARE_BTB_PREDICTOR -- requirements
Module: gshare_btb_predictor

---
 rtl/gshare_pkg.sv | 32 +++
 rtl/btb_dm.sv | 45 ++++
 rtl/gshare_btb_predictor.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gshare_pkg.sv
// Shared opcode constants, PHT counter helpers and FSM state type for the
// gshare branch predictor and its BTB.
package gshare_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] CTR_INIT = 2'b01;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  // Two-bit saturating counter step: never wraps past 00 or 11.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] result;
    result = ctr;
    if (taken && (ctr != 2'b11)) begin
      result = ctr + 2'b01;
    end else if (!taken && (ctr != 2'b00)) begin
      result = ctr - 2'b01;
    end
    return result;
  endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer: registered valid bits cleared by reset,
// tag/target storage without reset, combinational read and synchronous write.
module btb_dm #(
  parameter int ENTRY_IDX_W = 4,
  parameter int TAG_W       = 26,
  parameter int TGT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ENTRY_IDX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0]       rd_tag,
  output logic                   rd_hit,
  output logic [TGT_W-1:0]       rd_target,
  input  logic                   wr_en,
  input  logic [ENTRY_IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]       wr_tag,
  input  logic [TGT_W-1:0]       wr_target
);

  localparam int DEPTH = 1 << ENTRY_IDX_W;

  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tags    [DEPTH];
  logic [TGT_W-1:0] targets [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only trusted behind its valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx]    <= wr_tag;
      targets[wr_idx] <= wr_target;
    end
  end

  assign rd_hit    = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_target = targets[rd_idx];

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a direct-mapped BTB. After reset the PHT is
// swept to weakly-not-taken before requests and updates are accepted.
module gshare_btb_predictor
  import gshare_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int GHR_W     = 8,
  parameter int IDX_W     = 8,
  parameter int BTB_IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [PC_W-1:0]  req_pc,
  input  logic [6:0]       req_opcode,
  output logic             req_ready,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [6:0]       upd_opcode,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_mispredict
);

  localparam int PHT_DEPTH = 1 << IDX_W;
  localparam int TAG_W     = PC_W - BTB_IDX_W - 2;
  localparam int HIST_W    = (GHR_W < IDX_W) ? GHR_W : IDX_W;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  sweep_cnt;
  logic              sweep_last;
  logic              ready;
  logic              accept;
  logic              upd_ok;
  logic              req_is_branch;
  logic              req_is_jump;
  logic              upd_is_branch;
  logic [GHR_W-1:0]  ghr;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  upd_idx;
  logic [1:0]        pht [PHT_DEPTH];
  logic              btb_hit;
  logic [PC_W-1:0]   btb_target;
  logic [PC_W-1:0]   pc_plus4;
  logic              taken_d;
  logic [PC_W-1:0]   target_d;
  logic              pht_we;
  logic              btb_we;
  logic              unused_upd_bits;

  // History is zero-extended or truncated to the index width before hashing.
  function automatic logic [IDX_W-1:0] pht_index(input logic [IDX_W-1:0] pc_bits,
                                                 input logic [GHR_W-1:0] hist);
    logic [IDX_W-1:0] hist_ext;
    hist_ext = '0;
    hist_ext[HIST_W-1:0] = hist[HIST_W-1:0];
    return pc_bits ^ hist_ext;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (sweep_last) state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep_cnt <= '0;
    end else if (state == INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  assign sweep_last = (sweep_cnt == {IDX_W{1'b1}});
  assign ready      = (state == READY);
  assign req_ready  = ready;
  assign accept     = req_valid && ready;
  assign upd_ok     = upd_valid && ready;

  assign req_is_branch = (req_opcode == OP_BRANCH);
  assign req_is_jump   = (req_opcode == OP_JAL) || (req_opcode == OP_JALR);
  assign upd_is_branch = (upd_opcode == OP_BRANCH);

  assign req_idx = pht_index(req_pc[IDX_W+1:2], ghr);
  assign upd_idx = pht_index(upd_pc[IDX_W+1:2], upd_ghr);

  assign pht_we = upd_ok && upd_is_branch;
  assign btb_we = upd_ok && is_ctrl(upd_opcode) && upd_taken;

  assign unused_upd_bits = ^upd_pc[1:0];

  btb_dm #(
    .ENTRY_IDX_W (BTB_IDX_W),
    .TAG_W       (TAG_W),
    .TGT_W       (PC_W)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (req_pc[BTB_IDX_W+1:2]),
    .rd_tag    (req_pc[PC_W-1:BTB_IDX_W+2]),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (btb_we),
    .wr_idx    (upd_pc[BTB_IDX_W+1:2]),
    .wr_tag    (upd_pc[PC_W-1:BTB_IDX_W+2]),
    .wr_target (upd_target)
  );

  // PHT has no reset; the INIT sweep is what establishes its contents.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      pht[sweep_cnt] <= CTR_INIT;
    end else if (pht_we) begin
      pht[upd_idx] <= ctr_next(pht[upd_idx], upd_taken);
    end
  end

  assign pc_plus4 = req_pc + PC_W'(4);

  // A predicted-taken direction with no known target falls back to not-taken.
  always_comb begin
    taken_d = 1'b0;
    if (req_is_branch) begin
      taken_d = pht[req_idx][1] && btb_hit;
    end else if (req_is_jump) begin
      taken_d = btb_hit;
    end
    target_d = taken_d ? btb_target : pc_plus4;
  end

  // Mispredict recovery wins over a speculative shift in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr <= '0;
    end else if (upd_ok && upd_mispredict && upd_is_branch) begin
      ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
    end else if (accept && req_is_branch) begin
      ghr <= {ghr[GHR_W-2:0], taken_d};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      pred_ghr    <= '0;
    end else begin
      pred_valid <= accept;
      if (accept) begin
        pred_taken  <= taken_d;
        pred_target <= target_d;
        pred_ghr    <= ghr;
      end
    end
  end

endmodule
